// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register: valid/ready handshake with a two-entry skid buffer,
// synchronous flush, zeroed control on bubbles and a saturating stall counter.
module id_ex_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int OPF_W  = 6,
  parameter int CTRL_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [6*DATA_W-1:0]   in_words,
  input  logic [REG_W-1:0]      in_rt,
  input  logic [REG_W-1:0]      in_rd,
  input  logic [OPF_W-1:0]      in_op,
  input  logic [OPF_W-1:0]      in_funct,
  input  logic [CTRL_W-1:0]     in_ctrl,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [6*DATA_W-1:0]   out_words,
  output logic [REG_W-1:0]      out_rt,
  output logic [REG_W-1:0]      out_rd,
  output logic [OPF_W-1:0]      out_op,
  output logic [OPF_W-1:0]      out_funct,
  output logic [CTRL_W-1:0]     out_ctrl,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int PAY_W = 6*DATA_W + 2*REG_W + 2*OPF_W;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic                r_inReady;
  logic [PAY_W-1:0]    r_mData;
  logic [PAY_W-1:0]    r_sData;
  logic [CTRL_W-1:0]   r_mCtrl;
  logic [CTRL_W-1:0]   r_sCtrl;
  logic [CNT_W-1:0]    r_stallCnt;
  logic [PAY_W-1:0]    w_inData;
  logic                w_accept;
  logic                w_drain;
  logic                w_loadM;
  logic                w_loadS;
  logic                w_moveS;

  assign w_inData = {in_words, in_rt, in_rd, in_op, in_funct};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Flush overrides every transition and suppresses all loads into M and S.
  always_comb begin
    w_nextState = r_state;
    w_loadM     = 1'b0;
    w_loadS     = 1'b0;
    w_moveS     = 1'b0;
    w_accept    = in_valid & r_inReady & ~flush;
    w_drain     = (r_state != EMPTY) & out_ready;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_nextState = ONE;
          w_loadM     = 1'b1;
        end
      end
      ONE: begin
        if (w_accept && w_drain) begin
          w_loadM = 1'b1;
        end else if (w_accept) begin
          w_nextState = TWO;
          w_loadS     = 1'b1;
        end else if (w_drain) begin
          w_nextState = EMPTY;
        end
      end
      TWO: begin
        if (w_drain) begin
          w_nextState = ONE;
          w_moveS     = 1'b1;
        end
      end
      default: w_nextState = EMPTY;
    endcase
    if (flush) begin
      w_nextState = EMPTY;
      w_loadM     = 1'b0;
      w_loadS     = 1'b0;
      w_moveS     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inReady <= 1'b0;
    end else begin
      r_inReady <= (w_nextState != TWO);
    end
  end

  // Data words keep their last value when an entry empties; only control is cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mData <= '0;
      r_mCtrl <= '0;
      r_sData <= '0;
      r_sCtrl <= '0;
    end else begin
      if (w_loadM) begin
        r_mData <= w_inData;
        r_mCtrl <= in_ctrl;
      end else if (w_moveS) begin
        r_mData <= r_sData;
        r_mCtrl <= r_sCtrl;
      end else if (w_nextState == EMPTY) begin
        r_mCtrl <= '0;
      end
      if (w_loadS) begin
        r_sData <= w_inData;
        r_sCtrl <= in_ctrl;
      end else if (w_moveS || flush) begin
        r_sCtrl <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stallCnt <= '0;
    end else if (out_valid && !out_ready && (r_stallCnt != {CNT_W{1'b1}})) begin
      r_stallCnt <= r_stallCnt + CNT_ONE;
    end
  end

  assign in_ready  = r_inReady;
  assign out_valid = (r_state != EMPTY);
  assign out_ctrl  = out_valid ? r_mCtrl : '0;
  assign {out_words, out_rt, out_rd, out_op, out_funct} = r_mData;
  assign stall_cnt = r_stallCnt;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-based reference model.
module tb_id_ex_pipe_reg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int OPF_W  = 6;
  localparam int CTRL_W = 10;
  localparam int CNT_W  = 4;
  localparam int STALL_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [6*DATA_W-1:0] words;
    logic [REG_W-1:0]    rt;
    logic [REG_W-1:0]    rd;
    logic [OPF_W-1:0]    op;
    logic [OPF_W-1:0]    funct;
    logic [CTRL_W-1:0]   ctrl;
  } beat_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                flush = 1'b0;
  logic                in_valid = 1'b0;
  logic                out_ready = 1'b0;
  logic                in_ready;
  logic                out_valid;
  beat_t               inBeat = '0;
  logic [6*DATA_W-1:0] out_words;
  logic [REG_W-1:0]    out_rt;
  logic [REG_W-1:0]    out_rd;
  logic [OPF_W-1:0]    out_op;
  logic [OPF_W-1:0]    out_funct;
  logic [CTRL_W-1:0]   out_ctrl;
  logic [CNT_W-1:0]    stall_cnt;
  beat_t               dutBeat;

  int nChecks = 0;
  int nFails  = 0;

  beat_t q[$];
  logic  readyExp = 1'b0;
  int    stallExp = 0;
  logic  mAccept;
  logic  mHadBeat;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(
    .DATA_W(DATA_W), .REG_W(REG_W), .OPF_W(OPF_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_words(inBeat.words), .in_rt(inBeat.rt), .in_rd(inBeat.rd),
    .in_op(inBeat.op), .in_funct(inBeat.funct), .in_ctrl(inBeat.ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_words(out_words), .out_rt(out_rt), .out_rd(out_rd),
    .out_op(out_op), .out_funct(out_funct), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt)
  );

  assign dutBeat = '{words: out_words, rt: out_rt, rd: out_rd, op: out_op,
                     funct: out_funct, ctrl: out_ctrl};

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most two beats; the head is what execute sees.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      readyExp = 1'b0;
      stallExp = 0;
    end else begin
      mAccept  = in_valid && readyExp && !flush;
      mHadBeat = (q.size() != 0);
      if (mHadBeat && !out_ready && stallExp < STALL_MAX) stallExp++;
      if (mHadBeat && out_ready) void'(q.pop_front());
      if (flush) q.delete();
      else if (mAccept) q.push_back(inBeat);
      readyExp = (q.size() < 2);
    end
  end

  always @(negedge clk) begin
    checkOutput("out_valid", {255'b0, out_valid}, {255'b0, q.size() != 0});
    checkOutput("in_ready", {255'b0, in_ready}, {255'b0, readyExp});
    checkOutput("stall_cnt", 256'(stall_cnt), 256'(stallExp));
    if (q.size() != 0) checkOutput("payload", 256'(dutBeat), 256'(q[0]));
    else checkOutput("bubble_ctrl", 256'(out_ctrl), 256'd0);
  end

  function automatic beat_t mkBeat(input logic [31:0] pc, input logic [CTRL_W-1:0] ctrl);
    beat_t b;
    b = '0;
    b.words[31:0] = pc;
    b.ctrl = ctrl;
    return b;
  endfunction

  function automatic beat_t randBeat();
    beat_t b;
    for (int i = 0; i < 6; i++) b.words[i*32 +: 32] = $urandom;
    b.rt    = REG_W'($urandom);
    b.rd    = REG_W'($urandom);
    b.op    = OPF_W'($urandom);
    b.funct = OPF_W'($urandom);
    b.ctrl  = CTRL_W'($urandom);
    return b;
  endfunction

  // Called at a negedge; drives one cycle of inputs and returns at the next negedge.
  task automatic applyStimulus(input logic v, input beat_t b, input logic rdy, input logic fl);
    #1;
    in_valid  = v;
    inBeat    = b;
    out_ready = rdy;
    flush     = fl;
    @(negedge clk);
  endtask

  task automatic doReset();
    #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    doReset();

    // Single beat, one-cycle latency
    applyStimulus(1'b1, mkBeat(32'h4, 10'h010), 1'b1, 1'b0);
    checkOutput("t1_valid", {255'b0, out_valid}, 256'd1);
    checkOutput("t1_pc", 256'(out_words[31:0]), 256'h4);
    checkOutput("t1_ctrl", 256'(out_ctrl), 256'h010);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("t1_drained", {255'b0, out_valid}, 256'd0);

    // Three-beat stream under backpressure
    doReset();
    applyStimulus(1'b1, mkBeat(32'h4, 10'h011), 1'b1, 1'b0);
    checkOutput("t2_out0", 256'(out_words[31:0]), 256'h4);
    applyStimulus(1'b1, mkBeat(32'h8, 10'h012), 1'b0, 1'b0);
    checkOutput("t2_ready_drop", {255'b0, in_ready}, 256'd0);
    applyStimulus(1'b1, mkBeat(32'hC, 10'h013), 1'b0, 1'b0);
    checkOutput("t2_hold", 256'(out_words[31:0]), 256'h4);
    applyStimulus(1'b1, mkBeat(32'hC, 10'h013), 1'b1, 1'b0);
    checkOutput("t2_out1", 256'(out_words[31:0]), 256'h8);
    applyStimulus(1'b1, mkBeat(32'hC, 10'h013), 1'b1, 1'b0);
    checkOutput("t2_out2", 256'(out_words[31:0]), 256'hC);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("t2_empty", {255'b0, out_valid}, 256'd0);
    checkOutput("t2_stall", 256'(stall_cnt), 256'd2);

    // Flush from TWO discards everything including the concurrent beat
    applyStimulus(1'b1, mkBeat(32'h10, 10'h3FF), 1'b0, 1'b0);
    applyStimulus(1'b1, mkBeat(32'h14, 10'h3FF), 1'b0, 1'b0);
    applyStimulus(1'b1, mkBeat(32'h18, 10'h3FF), 1'b0, 1'b1);
    checkOutput("t3_valid", {255'b0, out_valid}, 256'd0);
    checkOutput("t3_ctrl", 256'(out_ctrl), 256'd0);
    checkOutput("t3_ready", {255'b0, in_ready}, 256'd1);
    repeat (2) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("t3_no_ghost", {255'b0, out_valid}, 256'd0);

    // Stall counter saturation
    applyStimulus(1'b1, mkBeat(32'h20, 10'h004), 1'b0, 1'b0);
    repeat (20) applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("t4_sat", 256'(stall_cnt), 256'd15);

    // Asynchronous reset in the middle of a cycle while in TWO
    applyStimulus(1'b1, mkBeat(32'h24, 10'h008), 1'b0, 1'b0);
    checkOutput("t5_two", {255'b0, in_ready}, 256'd0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5_valid", {255'b0, out_valid}, 256'd0);
    checkOutput("t5_ctrl", 256'(out_ctrl), 256'd0);
    checkOutput("t5_stall", 256'(stall_cnt), 256'd0);
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Randomized traffic against the model
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 299) == 0) doReset();
      else applyStimulus($urandom_range(0, 9) < 7, randBeat(),
                         $urandom_range(0, 9) < 6, $urandom_range(0, 15) == 0);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
